// File: rtl/banco_reg_param_if.sv
// Bus bundle for banco_reg_param: write port, two read addresses, registered read data and ready flag.
// The master side (decode/writeback) drives addresses and write data; the bank is the slave.
interface banco_reg_param_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             WE;
  logic [AW-1:0]    DE;
  logic [WIDTH-1:0] Dato;
  logic [AW-1:0]    DL1;
  logic [AW-1:0]    DL2;
  logic [WIDTH-1:0] Q1;
  logic [WIDTH-1:0] Q2;
  logic             Listo;

  modport master (
    output WE, DE, Dato, DL1, DL2,
    input  Q1, Q2, Listo
  );

  modport slave (
    input  WE, DE, Dato, DL1, DL2,
    output Q1, Q2, Listo
  );
endinterface

// File: rtl/banco_reg_param.sv
// Clocked 2-read/1-write register bank with registered reads, optional write bypass and zero register.
// After reset every entry is swept to zero before Listo rises.
module banco_reg_param #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               rst,
  banco_reg_param_if.slave   bus
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    LIMPIAR = 1'b0,
    OPERAR  = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q1, r_q2;
  logic [WIDTH-1:0] w_q1_nxt, w_q2_nxt;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_addr;
  logic [WIDTH-1:0] w_mem_data;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    w_mem_addr  = bus.DE;
    w_mem_data  = bus.Dato;
    w_q1_nxt    = '0;
    w_q2_nxt    = '0;
    case (r_state)
      LIMPIAR: begin
        // Sweep one entry per cycle; outputs stay at zero until the bank is ready.
        w_mem_we   = 1'b1;
        w_mem_addr = r_cnt;
        w_mem_data = '0;
        w_cnt_nxt  = r_cnt + AW'(1);
        if (r_cnt == '1) w_state_nxt = OPERAR;
      end
      OPERAR: begin
        w_mem_we = bus.WE && !((ZERO_REG != 0) && (bus.DE == '0));
        // Priority: zero register, then same-cycle write bypass, then stored value.
        w_q1_nxt = r_mem[bus.DL1];
        if ((BYPASS != 0) && bus.WE && (bus.DE == bus.DL1)) w_q1_nxt = bus.Dato;
        if ((ZERO_REG != 0) && (bus.DL1 == '0))             w_q1_nxt = '0;
        w_q2_nxt = r_mem[bus.DL2];
        if ((BYPASS != 0) && bus.WE && (bus.DE == bus.DL2)) w_q2_nxt = bus.Dato;
        if ((ZERO_REG != 0) && (bus.DL2 == '0))             w_q2_nxt = '0;
      end
      default: w_state_nxt = LIMPIAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LIMPIAR;
      r_cnt   <= '0;
      r_q1    <= '0;
      r_q2    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q1    <= w_q1_nxt;
      r_q2    <= w_q2_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  assign bus.Q1    = r_q1;
  assign bus.Q2    = r_q2;
  assign bus.Listo = (r_state == OPERAR);
endmodule
